// File: rtl/norm_pkg.sv
// Shared types and helpers for the L1 psum normaliser: FSM states, width helper,
// and wide abs / sign-apply functions that callers size-cast to their own widths.
package norm_pkg;

  localparam int MAXW        = 64;
  localparam int DEF_BW_PSUM = 20;
  localparam int DEF_COL     = 8;
  localparam int DEF_FRAC    = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM,
    S_WAIT,
    S_DIV,
    S_OUT
  } state_e;

  function automatic int norm_clog2(input int n);
    int r;
    r = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  // Magnitude of a sign-extended value; the most negative input maps to +2^(W-1).
  function automatic logic [MAXW-1:0] norm_abs(input logic signed [MAXW-1:0] v);
    return v[MAXW-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic signed [MAXW-1:0] norm_apply_sign(input logic neg,
                                                             input logic [MAXW-1:0] mag);
    return neg ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/seq_div.sv
// Unsigned restoring divider producing a QW-bit quotient in exactly QW cycles.
// Caller guarantees quotient < 2^QW, so only the low QW dividend bits need shifting in.
module seq_div
  import norm_pkg::*;
#(
  parameter int NW = 28,
  parameter int DW = 24,
  parameter int QW = 9
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start_i,
  input  logic [NW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  output logic          run_o,
  output logic          done_o,
  output logic [QW-1:0] quo_o
);
  localparam int SW = norm_clog2(QW + 1);

  logic          run_q;
  logic [SW-1:0] cnt_q, step_d;
  logic [DW-1:0] rem_q, rem_in, rem_d;
  logic [QW-1:0] bits_q, bits_in, quo_q, quo_in, quo_d;
  logic [DW:0]   trial;
  logic          ge;

  always_comb begin
    if (start_i) begin
      rem_in  = DW'(dividend_i[NW-1:QW]);
      bits_in = dividend_i[QW-1:0];
      quo_in  = '0;
      step_d  = '0;
    end else begin
      rem_in  = rem_q;
      bits_in = bits_q;
      quo_in  = quo_q;
      step_d  = cnt_q;
    end
    trial  = {rem_in, bits_in[QW-1]};
    ge     = (trial >= {1'b0, divisor_i});
    rem_d  = ge ? DW'(trial - {1'b0, divisor_i}) : DW'(trial);
    quo_d  = (quo_in << 1) | QW'(ge);
    done_o = (start_i || run_q) && (step_d == SW'(QW - 1));
  end

  assign quo_o = quo_d;
  assign run_o = run_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      run_q <= 1'b0;
    end else if (start_i || run_q) begin
      rem_q  <= rem_d;
      bits_q <= bits_in << 1;
      quo_q  <= quo_d;
      cnt_q  <= step_d + SW'(1);
      run_q  <= !done_o;
    end
  end

endmodule

// File: rtl/psum_norm.sv
// L1 normaliser: sums |psum| over a row, optionally merges a partner core's sum,
// then divides each channel by the saturated total with one shared sequential divider.
module psum_norm
  import norm_pkg::*;
#(
  parameter int bw_psum = DEF_BW_PSUM,
  parameter int col     = DEF_COL,
  parameter int frac    = DEF_FRAC,
  parameter int bw_sum  = bw_psum + 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   mode,
  input  logic                   solo,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [bw_psum*col-1:0] in,
  output logic [bw_sum-1:0]      sum_out,
  output logic                   sum_out_valid,
  input  logic [bw_sum-1:0]      sum_in,
  input  logic                   sum_in_valid,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [bw_psum*col-1:0] out,
  output logic                   div_zero,
  output logic                   busy
);
  localparam int CW = norm_clog2(col);
  localparam int NW = bw_psum + frac;
  localparam int QW = frac + 1;

  state_e                     state_q;
  logic                       solo_q, pflag_q;
  logic [bw_sum-1:0]          psum_q, total_q, sum_out_q;
  logic                       sum_out_valid_q, div_zero_q;
  logic [CW-1:0]              ch_q;
  logic signed [bw_psum-1:0]  row_q [col];
  logic signed [bw_psum-1:0]  out_q [col];
  logic [bw_psum-1:0]         abs_row [col];
  logic [bw_sum-1:0]          local_d, partner_d, total_d;
  logic                       wait_go;
  logic                       dv_start, dv_run, dv_done;
  logic [QW-1:0]              dv_quo;
  logic [NW-1:0]              dv_dividend;

  function automatic logic [bw_sum-1:0] sat_add(input logic [bw_sum-1:0] a,
                                                input logic [bw_sum-1:0] b);
    logic [bw_sum:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[bw_sum] ? '1 : s[bw_sum-1:0];
  endfunction

  for (genvar k = 0; k < col; k++) begin : g_ch
    assign abs_row[k] = bw_psum'(norm_abs(MAXW'(row_q[k])));
    assign out[bw_psum*k +: bw_psum] = out_q[k];
  end

  always_comb begin
    local_d = '0;
    for (int k = 0; k < col; k++) local_d = local_d + bw_sum'(abs_row[k]);
    // A strobe arriving in the same WAIT cycle is the newest partner value.
    partner_d   = solo_q ? '0 : (sum_in_valid ? sum_in : psum_q);
    total_d     = sat_add(sum_out_q, partner_d);
    wait_go     = solo_q || pflag_q || sum_in_valid;
    dv_dividend = NW'(abs_row[ch_q]) << frac;
    dv_start    = (state_q == S_DIV) && !dv_run;
  end

  seq_div #(.NW(NW), .DW(bw_sum), .QW(QW)) u_div (
    .clk        (clk),
    .reset      (reset),
    .start_i    (dv_start),
    .dividend_i (dv_dividend),
    .divisor_i  (total_q),
    .run_o      (dv_run),
    .done_o     (dv_done),
    .quo_o      (dv_quo)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q         <= S_IDLE;
      sum_out_q       <= '0;
      sum_out_valid_q <= 1'b0;
      div_zero_q      <= 1'b0;
      pflag_q         <= 1'b0;
      for (int k = 0; k < col; k++) out_q[k] <= '0;
    end else begin
      sum_out_valid_q <= 1'b0;
      if ((state_q == S_SUM || state_q == S_WAIT) && sum_in_valid) begin
        psum_q  <= sum_in;
        pflag_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: if (in_valid) begin
          for (int k = 0; k < col; k++) row_q[k] <= in[bw_psum*k +: bw_psum];
          solo_q     <= solo;
          pflag_q    <= 1'b0;
          div_zero_q <= 1'b0;
          if (mode) begin
            for (int k = 0; k < col; k++) out_q[k] <= in[bw_psum*k +: bw_psum];
            state_q <= S_OUT;
          end else begin
            state_q <= S_SUM;
          end
        end
        S_SUM: begin
          sum_out_q       <= local_d;
          sum_out_valid_q <= 1'b1;
          state_q         <= S_WAIT;
        end
        S_WAIT: if (wait_go) begin
          if (total_d == '0) begin
            for (int k = 0; k < col; k++) out_q[k] <= '0;
            div_zero_q <= 1'b1;
            state_q    <= S_OUT;
          end else begin
            total_q <= total_d;
            ch_q    <= '0;
            state_q <= S_DIV;
          end
        end
        S_DIV: if (dv_done) begin
          out_q[ch_q] <= bw_psum'(norm_apply_sign(row_q[ch_q][bw_psum-1], MAXW'(dv_quo)));
          if (ch_q == CW'(col - 1)) state_q <= S_OUT;
          else                      ch_q    <= ch_q + CW'(1);
        end
        S_OUT: if (out_ready) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready      = reset && (state_q == S_IDLE);
  assign busy          = (state_q != S_IDLE);
  assign out_valid     = (state_q == S_OUT);
  assign sum_out       = sum_out_q;
  assign sum_out_valid = sum_out_valid_q;
  assign div_zero      = div_zero_q;

endmodule

// File: tb/tb_psum_norm.sv
// Directed bench for psum_norm at default parameters (20-bit psums, 8 channels, 8 fraction bits).
module tb_psum_norm;
  localparam int BW   = 20;
  localparam int COL  = 8;
  localparam int FR   = 8;
  localparam int SW   = BW + 4;
  localparam int ROWW = BW * COL;

  logic            clk = 1'b0;
  logic            reset, mode, solo, in_valid, in_ready;
  logic            sum_out_valid, sum_in_valid, out_valid, out_ready, div_zero, busy;
  logic [ROWW-1:0] in_row, out_row;
  logic [SW-1:0]   sum_out, sum_in;
  int              n_run = 0;
  int              n_fail = 0;
  // lat = index of the edge, counted from the handshake edge, whose sampling is visible now
  int              lat, sov_cnt, sov_lat;

  always #5 clk = ~clk;

  psum_norm #(.bw_psum(BW), .col(COL), .frac(FR), .bw_sum(SW)) dut (
    .clk           (clk),
    .reset         (reset),
    .mode          (mode),
    .solo          (solo),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in            (in_row),
    .sum_out       (sum_out),
    .sum_out_valid (sum_out_valid),
    .sum_in        (sum_in),
    .sum_in_valid  (sum_in_valid),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out           (out_row),
    .div_zero      (div_zero),
    .busy          (busy)
  );

  function automatic logic [ROWW-1:0] row8(input int a0, input int a1, input int a2, input int a3,
                                           input int a4, input int a5, input int a6, input int a7);
    int v [8];
    logic [ROWW-1:0] r;
    v = '{a0, a1, a2, a3, a4, a5, a6, a7};
    r = '0;
    for (int k = 0; k < 8; k++) r[k*BW +: BW] = BW'(v[k]);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic step();
    tick();
    lat++;
    if (sum_out_valid === 1'b1) begin
      if (sov_cnt == 0) sov_lat = lat;
      sov_cnt++;
    end
  endtask

  task automatic send_row(input logic [ROWW-1:0] r, input logic m, input logic s);
    int guard;
    guard = 0;
    while (in_ready !== 1'b1 && guard < 100) begin tick(); guard++; end
    n_run++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL in_ready_wait: in_ready=%b want 1", in_ready); end
    in_row = r; mode = m; solo = s; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1; sov_cnt = 0; sov_lat = 0;
  endtask

  task automatic wait_out();
    while (out_valid !== 1'b1 && lat < 400) step();
    n_run++;
    if (out_valid !== 1'b1) begin
      n_fail++; $display("FAIL out_valid_timeout: out_valid=%b after %0d cycles, want 1", out_valid, lat);
    end
  endtask

  task automatic accept();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_run++; if (out_row !== '0) begin n_fail++; $display("FAIL rst_out: got %h want 0", out_row); end
    n_run++; if (sum_out !== '0) begin n_fail++; $display("FAIL rst_sum_out: got %h want 0", sum_out); end
    n_run++; if (sum_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_sov: got %b want 0", sum_out_valid); end
    n_run++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL rst_div_zero: got %b want 0", div_zero); end
    n_run++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    reset = 1'b1;
    #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rst_release_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_solo();
    logic [ROWW-1:0] exp_row;
    exp_row = row8(128, -128, 0, 0, 0, 0, 0, 0);
    send_row(row8(100, -100, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL solo_busy: got %b want 1", busy); end
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL solo_in_ready: got %b want 0", in_ready); end
    wait_out();
    n_run++; if (lat != 75) begin n_fail++; $display("FAIL solo_latency: got %0d want 75", lat); end
    n_run++; if (sov_cnt != 1) begin n_fail++; $display("FAIL solo_sov_count: got %0d want 1", sov_cnt); end
    n_run++; if (sov_lat != 2) begin n_fail++; $display("FAIL solo_sov_time: got %0d want 2", sov_lat); end
    n_run++; if (sum_out !== SW'(200)) begin n_fail++; $display("FAIL solo_sum_out: got %0d want 200", sum_out); end
    n_run++; if (out_row !== exp_row) begin n_fail++; $display("FAIL solo_out: got %h want %h", out_row, exp_row); end
    n_run++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL solo_div_zero: got %b want 0", div_zero); end
    accept();
    n_run++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL solo_accept_valid: got %b want 0", out_valid); end
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL solo_accept_ready: got %b want 1", in_ready); end
    n_run++; if (out_row !== exp_row) begin n_fail++; $display("FAIL solo_out_retain: got %h want %h", out_row, exp_row); end
  endtask

  task automatic test_partner();
    logic [ROWW-1:0] exp_row;
    exp_row = row8(100, -100, 0, 0, 0, 0, 0, 0);
    send_row(row8(100, -100, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0);
    sum_in = SW'(1000); sum_in_valid = 1'b1;
    step();
    sum_in = SW'(56);
    step();
    sum_in_valid = 1'b0;
    wait_out();
    n_run++; if (lat != 75) begin n_fail++; $display("FAIL partner_latency: got %0d want 75", lat); end
    n_run++; if (sum_out !== SW'(200)) begin n_fail++; $display("FAIL partner_sum_out: got %0d want 200", sum_out); end
    n_run++; if (out_row !== exp_row) begin n_fail++; $display("FAIL partner_out: got %h want %h", out_row, exp_row); end
    accept();
  endtask

  task automatic test_zero();
    send_row('0, 1'b0, 1'b1);
    wait_out();
    n_run++; if (lat != 3) begin n_fail++; $display("FAIL zero_latency: got %0d want 3", lat); end
    n_run++; if (div_zero !== 1'b1) begin n_fail++; $display("FAIL zero_div_zero: got %b want 1", div_zero); end
    n_run++; if (out_row !== '0) begin n_fail++; $display("FAIL zero_out: got %h want 0", out_row); end
    accept();
  endtask

  task automatic test_bypass();
    logic [ROWW-1:0] r;
    int highs;
    r = row8(12345, -7, 524287, -524288, 0, 1, -1, 99999);
    send_row(r, 1'b1, 1'b0);
    wait_out();
    n_run++; if (lat != 1) begin n_fail++; $display("FAIL bypass_latency: got %0d want 1", lat); end
    n_run++; if (out_row !== r) begin n_fail++; $display("FAIL bypass_out: got %h want %h", out_row, r); end
    n_run++; if (div_zero !== 1'b0) begin n_fail++; $display("FAIL bypass_div_zero: got %b want 0", div_zero); end
    highs = 0;
    repeat (3) begin
      if (sum_out_valid === 1'b1) highs++;
      tick();
    end
    n_run++; if (highs != 0) begin n_fail++; $display("FAIL bypass_sov: got %0d pulses want 0", highs); end
    accept();
  endtask

  task automatic test_minval_stall();
    logic [ROWW-1:0] exp_row;
    exp_row = row8(-256, 0, 0, 0, 0, 0, 0, 0);
    send_row(row8(-524288, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1);
    wait_out();
    n_run++; if (lat != 75) begin n_fail++; $display("FAIL minval_latency: got %0d want 75", lat); end
    n_run++; if (sum_out !== SW'(524288)) begin n_fail++; $display("FAIL minval_sum_out: got %0d want 524288", sum_out); end
    in_row = row8(5, 6, 7, 8, 0, 0, 0, 0); mode = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      n_run++;
      if ({out_valid, in_ready, out_row} !== {1'b1, 1'b0, exp_row}) begin
        n_fail++; $display("FAIL stall_hold_%0d: valid=%b ready=%b out=%h want valid=1 ready=0 out=%h",
                           i, out_valid, in_ready, out_row, exp_row);
      end
      tick();
    end
    in_valid = 1'b0;
    accept();
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release_ready: got %b want 1", in_ready); end
    n_run++; if (out_row !== exp_row) begin n_fail++; $display("FAIL stall_out_retain: got %h want %h", out_row, exp_row); end
  endtask

  task automatic test_saturate();
    logic [ROWW-1:0] exp_row;
    exp_row = row8(-8, -8, -8, -8, -8, -8, -8, -8);
    send_row(row8(-524288, -524288, -524288, -524288, -524288, -524288, -524288, -524288), 1'b0, 1'b0);
    step();
    repeat (3) step();
    n_run++; if ({out_valid, busy} !== 2'b01) begin n_fail++; $display("FAIL sat_waiting: valid,busy=%b want 01", {out_valid, busy}); end
    n_run++; if (sum_out !== SW'(4194304)) begin n_fail++; $display("FAIL sat_sum_out: got %0d want 4194304", sum_out); end
    sum_in = '1; sum_in_valid = 1'b1;
    step();
    sum_in_valid = 1'b0;
    wait_out();
    n_run++; if (lat != 78) begin n_fail++; $display("FAIL sat_latency: got %0d want 78", lat); end
    n_run++; if (out_row !== exp_row) begin n_fail++; $display("FAIL sat_out: got %h want %h", out_row, exp_row); end
    accept();
  endtask

  task automatic test_floor();
    logic [ROWW-1:0] exp_row;
    exp_row = row8(42, -85, 0, 0, 0, 0, 0, 128);
    send_row(row8(1, -2, 0, 0, 0, 0, 0, 3), 1'b0, 1'b1);
    wait_out();
    n_run++; if (out_row !== exp_row) begin n_fail++; $display("FAIL floor_out: got %h want %h", out_row, exp_row); end
    accept();
  endtask

  task automatic test_reset_mid();
    logic [ROWW-1:0] r, exp_row;
    int highs;
    r       = row8(50, -150, 200, -400, 0, 0, 0, 0);
    exp_row = row8(16, -48, 64, -128, 0, 0, 0, 0);
    send_row(r, 1'b0, 1'b1);
    repeat (10) step();
    n_run++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b0;
    tick();
    n_run++; if (out_row !== '0) begin n_fail++; $display("FAIL mid_out: got %h want 0", out_row); end
    n_run++; if ({out_valid, busy, sum_out_valid} !== 3'b000) begin
      n_fail++; $display("FAIL mid_ctrl: valid,busy,sov=%b want 000", {out_valid, busy, sum_out_valid});
    end
    n_run++; if (sum_out !== '0) begin n_fail++; $display("FAIL mid_sum_out: got %h want 0", sum_out); end
    n_run++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_ready_low: got %b want 0", in_ready); end
    reset = 1'b1;
    #1;
    n_run++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready_release: got %b want 1", in_ready); end
    highs = 0;
    repeat (80) begin
      tick();
      if (out_valid === 1'b1) highs++;
    end
    n_run++; if (highs != 0) begin n_fail++; $display("FAIL mid_no_output: got %0d valid cycles want 0", highs); end
    send_row(r, 1'b0, 1'b1);
    wait_out();
    n_run++; if (lat != 75) begin n_fail++; $display("FAIL mid_next_latency: got %0d want 75", lat); end
    n_run++; if (out_row !== exp_row) begin n_fail++; $display("FAIL mid_next_out: got %h want %h", out_row, exp_row); end
    n_run++; if (sum_out !== SW'(800)) begin n_fail++; $display("FAIL mid_next_sum: got %0d want 800", sum_out); end
    accept();
  endtask

  initial begin
    reset = 1'b0; mode = 1'b0; solo = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    sum_in = '0; sum_in_valid = 1'b0; in_row = '0;
    lat = 0; sov_cnt = 0; sov_lat = 0;
    test_reset();
    test_solo();
    test_partner();
    test_zero();
    test_bypass();
    test_minval_stall();
    test_saturate();
    test_floor();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/psum_norm.md
# psum_norm

Parametrised L1 normaliser for the post-array partial-sum path: takes one row of `col` signed psums, forms the local sum of absolute values, optionally merges a partner core's sum, and divides each channel by the total using a shared sequential restoring divider. It generalises the fixed 8-column normaliser with parametrised column count and fraction bits, valid/ready handshakes, a bypass mode, solo (single-core) operation, and defined divide-by-zero behaviour. It sits between the OFIFO/psum buffer and SRAM write-back.

## Interface
- `bw_psum`, 20, psum width (signed)
- `col`, 8, channel count (≥2)
- `frac`, 8, output fraction bits; requires `frac` ≤ `bw_psum`-2
- `bw_sum`, `bw_psum`+4, width of sum ports (unsigned); requires `bw_sum` ≥ `bw_psum`+clog2(`col`)+1
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-low reset
- `mode`  in  1  0 = normalise, 1 = bypass; sampled at input handshake
- `solo`  in  1  1 = do not wait for `sum_in`; sampled at input handshake
- `in_valid`  in  1  input row valid
- `in_ready`  out  1  high only in IDLE
- `in`  in  `bw_psum`*`col`  channel k at bits [`bw_psum`*(k+1)-1 : `bw_psum`*k]
- `sum_out`  out  `bw_sum`  local sum of |psum|, zero-extended
- `sum_out_valid`  out  1  one-cycle pulse
- `sum_in`  in  `bw_sum`  partner core's local sum
- `sum_in_valid`  in  1  partner sum strobe
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer accepts
- `out`  out  `bw_psum`*`col`  normalised (or bypassed) row, same packing as `in`
- `div_zero`  out  1  total was 0; qualified by `out_valid`
- `busy`  out  1  state ≠ IDLE

## Operation
- States: IDLE, SUM, WAIT, DIV, OUT.
- IDLE: `in_ready`=1. On `in_valid`&&`in_ready`: register `in`, `mode`, `solo`; clear partner-sum flag. Go to OUT if `mode`=1 (out = stored `in`, `div_zero`=0), else SUM.
- SUM (1 cycle): abs_k = |psum_k| as unsigned `bw_psum` bits (-2^(`bw_psum`-1) → 2^(`bw_psum`-1), no overflow); local = Σ abs_k; register `sum_out`, pulse `sum_out_valid`. Go to WAIT.
- `sum_in` is captured on `sum_in_valid` in SUM or WAIT only; ignored in other states; a later strobe overwrites an earlier one.
- WAIT: leave when `solo`=1 (partner = 0) or partner flag set (same-cycle strobe counts). total = local + partner, saturated at 2^`bw_sum`-1. total = 0 → all channels 0, `div_zero`=1, go to OUT. Else go to DIV.
- DIV: channels 0..`col`-1 in order, each `frac`+1 cycles of restoring division: q = floor((abs_k << `frac`) / total), q ≤ 2^`frac`. Result = sign_k ? -q : q, written to out slot k. After last channel go to OUT.
- OUT: `out_valid`=1, `out`/`div_zero` stable until `out_valid`&&`out_ready`, then IDLE. `out` retains its value afterwards.

## Timing
- Reset (`reset`=0 at a clk edge): state IDLE; `out`, `sum_out`, `sum_out_valid`, `out_valid`, `div_zero`, `busy` = 0; `in_ready` = 0 while reset low, 1 on first cycle after release. Mid-operation reset aborts; no `out_valid` is produced.
- Handshake at edge T. Normalise, solo: SUM at T+1, `sum_out_valid` at T+2 (WAIT), DIV T+3 … T+2+`col`*(`frac`+1), `out_valid` from T+3+`col`*(`frac`+1) (75 cycles at defaults).
- Partner mode: DIV starts the cycle after WAIT sees the flag.
- Zero total: `out_valid` at T+3. Bypass: `out_valid` at T+1.
- Throughput: one row per transaction; next `in_ready` the cycle after the output handshake.

## Structure
- Package `norm_pkg`: state enum, clog2 function, abs/sign-apply functions, width constants.
- Sub-module `seq_div`: unsigned restoring divider with start/done, dividend `bw_psum`+`frac` bits, divisor `bw_sum` bits, quotient `frac`+1 bits, exactly `frac`+1 cycles.

## Test plan
- Solo, ch0=100, ch1=-100, others 0 → `sum_out`=200; out ch0=128, ch1=-128, others 0; `out_valid` exactly 75 cycles after handshake.
- Partner: same row, `sum_in`=56 strobed during WAIT → total 256; ch0=100, ch1=-100.
- All-zero row, solo → `div_zero`=1, `out`=0, `out_valid` at T+3.
- Bypass, arbitrary row → `out`==`in`, `out_valid` at T+1, no `sum_out_valid` pulse.
- Solo, ch0=-2^19, others 0 → ch0=-256. `out_ready` held low 10 cycles → `out` stable, `in_ready`=0, `in_valid` ignored.
- `reset` low during DIV → all outputs 0 next cycle, no `out_valid`; `in_ready`=1 after release; next row processes correctly.
